// File: rtl/pc_select_freg_pkg.sv
// Shared Y86-64 definitions for the F-stage PC select block: word type, icodes and status codes.
package pc_select_freg_pkg;

    localparam int unsigned WordW = 64;

    typedef logic [WordW-1:0] word_t;

    localparam logic [3:0] IcodeHalt = 4'h0;
    localparam logic [3:0] IcodeJxx  = 4'h7;
    localparam logic [3:0] IcodeCall = 4'h8;
    localparam logic [3:0] IcodeRet  = 4'h9;

    typedef enum logic [2:0] {
        StatAok = 3'd1,
        StatHlt = 3'd2,
        StatAdr = 3'd3,
        StatIns = 3'd4
    } stat_e;

endpackage

// File: rtl/pc_select_freg_if.sv
// Bus between pipeline/fetch and the F-stage PC select block.
// Counter outputs exist only when PC_SELECT_PERF_EN is defined.
interface pc_select_freg_if;
    import pc_select_freg_pkg::*;

    logic       F_stall;
    logic [3:0] f_icode;
    word_t      f_valC;
    word_t      f_valP;
    logic       f_instr_valid;
    logic       f_imem_error;
    logic [3:0] M_icode;
    logic       M_Cnd;
    word_t      M_valA;
    logic [3:0] W_icode;
    word_t      W_valM;
    logic [2:0] W_stat;
    word_t      f_pc;
    word_t      f_predPC;
    word_t      F_predPC;
    logic [2:0] f_stat;
    logic       halted;
`ifdef PC_SELECT_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] redirect_count;
`endif

    modport master (
        output F_stall, f_icode, f_valC, f_valP, f_instr_valid, f_imem_error,
        output M_icode, M_Cnd, M_valA, W_icode, W_valM, W_stat,
        input  f_pc, f_predPC, F_predPC, f_stat, halted
`ifdef PC_SELECT_PERF_EN
        , input fetch_count, redirect_count
`endif
    );

    modport slave (
        input  F_stall, f_icode, f_valC, f_valP, f_instr_valid, f_imem_error,
        input  M_icode, M_Cnd, M_valA, W_icode, W_valM, W_stat,
        output f_pc, f_predPC, F_predPC, f_stat, halted
`ifdef PC_SELECT_PERF_EN
        , output fetch_count, redirect_count
`endif
    );

endinterface

// File: rtl/pc_select_freg_pc_predictor.sv
// Combinational next-PC prediction and fetched-instruction status for the F stage.
module pc_select_freg_pc_predictor
    import pc_select_freg_pkg::*;
(
    input  logic [3:0] f_icode_i,
    input  word_t      f_valc_i,
    input  word_t      f_valp_i,
    input  logic       f_instr_valid_i,
    input  logic       f_imem_error_i,
    output word_t      f_predpc_o,
    output logic [2:0] f_stat_o
);

    // Jumps are predicted taken; calls always go to the target.
    always_comb begin
        f_predpc_o = f_valp_i;
        if (f_icode_i == IcodeJxx || f_icode_i == IcodeCall) begin
            f_predpc_o = f_valc_i;
        end
    end

    always_comb begin
        f_stat_o = StatAok;
        if (f_imem_error_i) begin
            f_stat_o = StatAdr;
        end else if (!f_instr_valid_i) begin
            f_stat_o = StatIns;
        end else if (f_icode_i == IcodeHalt) begin
            f_stat_o = StatHlt;
        end
    end

endmodule

// File: rtl/pc_select_freg.sv
// F-stage predicted-PC register, fetch PC select and sticky halt latch.
// Define PC_SELECT_PERF_EN to add saturating fetch/redirect counters.
module pc_select_freg
    import pc_select_freg_pkg::*;
#(
    parameter word_t RESET_PC = 64'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_select_freg_if.slave  bus
);

    word_t pred_pc_q, pred_pc_d;
    logic  halted_q, halted_d;
    word_t f_predpc;
    logic  mispredict, ret_redirect, fetch_en;

    pc_select_freg_pc_predictor u_pc_predictor (
        .f_icode_i       (bus.f_icode),
        .f_valc_i        (bus.f_valC),
        .f_valp_i        (bus.f_valP),
        .f_instr_valid_i (bus.f_instr_valid),
        .f_imem_error_i  (bus.f_imem_error),
        .f_predpc_o      (f_predpc),
        .f_stat_o        (bus.f_stat)
    );

    // Mispredict recovery from M outranks a ret target arriving in W.
    always_comb begin
        mispredict   = (bus.M_icode == IcodeJxx) && !bus.M_Cnd;
        ret_redirect = (bus.W_icode == IcodeRet);
        fetch_en     = !bus.F_stall && !halted_q;
        bus.f_pc     = pred_pc_q;
        if (mispredict) begin
            bus.f_pc = bus.M_valA;
        end else if (ret_redirect) begin
            bus.f_pc = bus.W_valM;
        end
    end

    always_comb begin
        pred_pc_d = pred_pc_q;
        halted_d  = halted_q;
        if (fetch_en) begin
            pred_pc_d = f_predpc;
        end
        if (bus.W_stat != StatAok) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_pc_q <= RESET_PC;
            halted_q  <= 1'b0;
        end else begin
            pred_pc_q <= pred_pc_d;
            halted_q  <= halted_d;
        end
    end

    assign bus.f_predPC = f_predpc;
    assign bus.F_predPC = pred_pc_q;
    assign bus.halted   = halted_q;

`ifdef PC_SELECT_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (fetch_en && fetch_cnt_q != 32'hFFFF_FFFF) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if ((mispredict || ret_redirect) && redir_cnt_q != 32'hFFFF_FFFF) begin
            redir_cnt_d = redir_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            redir_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign bus.fetch_count    = fetch_cnt_q;
    assign bus.redirect_count = redir_cnt_q;
`endif

endmodule

// File: tb/tb_pc_select_freg.sv
// Self-checking bench for pc_select_freg: vector table, directed corner sequences, random vs model.
module tb_pc_select_freg;
    import pc_select_freg_pkg::*;

    localparam logic [63:0] RstPc = 64'h100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    pc_select_freg_if bus();

    pc_select_freg #(.RESET_PC(RstPc)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference state: what the block should hold after each edge.
    logic [63:0] m_pred;
    logic        m_halted;
    logic [31:0] m_fetch;
    logic [31:0] m_redir;

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        valid;
        logic        imem;
        logic [63:0] exp_pred;
        logic [2:0]  exp_stat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_predpc();
        return (bus.f_icode == 4'd7 || bus.f_icode == 4'd8) ? bus.f_valC : bus.f_valP;
    endfunction

    function automatic logic [2:0] ref_stat();
        if (bus.f_imem_error) return 3'd3;
        if (!bus.f_instr_valid) return 3'd4;
        if (bus.f_icode == 4'd0) return 3'd2;
        return 3'd1;
    endfunction

    function automatic logic ref_redirect();
        return (bus.M_icode == 4'd7 && !bus.M_Cnd) || bus.W_icode == 4'd9;
    endfunction

    function automatic logic [63:0] ref_fpc();
        if (bus.M_icode == 4'd7 && !bus.M_Cnd) return bus.M_valA;
        if (bus.W_icode == 4'd9) return bus.W_valM;
        return m_pred;
    endfunction

    task automatic model_reset();
        m_pred   = RstPc;
        m_halted = 1'b0;
        m_fetch  = '0;
        m_redir  = '0;
    endtask

    // Advance one clock; the model sees the same inputs the DUT sampled.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (ref_redirect() && m_redir != '1) m_redir = m_redir + 1;
            if (!bus.F_stall && !m_halted) begin
                m_pred = ref_predpc();
                if (m_fetch != '1) m_fetch = m_fetch + 1;
            end
            if (bus.W_stat != 3'd1) m_halted = 1'b1;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".f_pc"}, bus.f_pc, ref_fpc());
        chk({tag, ".f_predPC"}, bus.f_predPC, ref_predpc());
        chk({tag, ".f_stat"}, 64'(bus.f_stat), 64'(ref_stat()));
        chk({tag, ".F_predPC"}, bus.F_predPC, m_pred);
        chk({tag, ".halted"}, 64'(bus.halted), 64'(m_halted));
`ifdef PC_SELECT_PERF_EN
        chk({tag, ".fetch_count"}, 64'(bus.fetch_count), 64'(m_fetch));
        chk({tag, ".redirect_count"}, 64'(bus.redirect_count), 64'(m_redir));
`endif
    endtask

    task automatic idle_inputs();
        bus.F_stall       = 1'b1;
        bus.f_icode       = 4'h1;
        bus.f_valC        = '0;
        bus.f_valP        = '0;
        bus.f_instr_valid = 1'b1;
        bus.f_imem_error  = 1'b0;
        bus.M_icode       = 4'h1;
        bus.M_Cnd         = 1'b1;
        bus.M_valA        = '0;
        bus.W_icode       = 4'h1;
        bus.W_valM        = '0;
        bus.W_stat        = 3'd1;
    endtask

    // Reset asserted mid-cycle, checked before any clock edge, released mid-cycle.
    task automatic async_reset_pulse(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ".rst_F_predPC"}, bus.F_predPC, RstPc);
        chk({tag, ".rst_halted"}, 64'(bus.halted), 64'd0);
        check_all({tag, ".rst"});
        tick();
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    logic [63:0] frozen;
    logic [31:0] redir_before;

    initial begin
        vecs[0] = '{4'h8, 64'h200, 64'h109, 1'b1, 1'b0, 64'h200, 3'd1};
        vecs[1] = '{4'h7, 64'hABC, 64'h9, 1'b1, 1'b0, 64'hABC, 3'd1};
        vecs[2] = '{4'h9, 64'h111, 64'h1234, 1'b1, 1'b0, 64'h1234, 3'd1};
        vecs[3] = '{4'h0, 64'h5, 64'h6, 1'b1, 1'b0, 64'h6, 3'd2};
        vecs[4] = '{4'h0, 64'h5, 64'h6, 1'b1, 1'b1, 64'h6, 3'd3};
        vecs[5] = '{4'h8, 64'h7, 64'h8, 1'b0, 1'b0, 64'h7, 3'd4};
        vecs[6] = '{4'h8, 64'h7, 64'h8, 1'b0, 1'b1, 64'h7, 3'd3};
        vecs[7] = '{4'h6, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
                    3'd1};

        idle_inputs();
        model_reset();
        #22;
        chk("reset.F_predPC", bus.F_predPC, RstPc);
        chk("reset.f_pc", bus.f_pc, RstPc);
        chk("reset.halted", 64'(bus.halted), 64'd0);
        check_all("reset");
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Prediction and status vectors with the register stalled.
        foreach (vecs[i]) begin
            bus.f_icode       = vecs[i].icode;
            bus.f_valC        = vecs[i].valc;
            bus.f_valP        = vecs[i].valp;
            bus.f_instr_valid = vecs[i].valid;
            bus.f_imem_error  = vecs[i].imem;
            #1;
            chk($sformatf("vec%0d.f_predPC", i), bus.f_predPC, vecs[i].exp_pred);
            chk($sformatf("vec%0d.f_stat", i), 64'(bus.f_stat), 64'(vecs[i].exp_stat));
        end
        tick();
        check_all("vec_done");

        // Call: target becomes the next fetch PC one cycle later.
        bus.F_stall = 1'b0; bus.f_icode = 4'h8; bus.f_valC = 64'h200; bus.f_valP = 64'h109;
        bus.f_instr_valid = 1'b1; bus.f_imem_error = 1'b0;
        tick();
        chk("call.F_predPC", bus.F_predPC, 64'h200);
        chk("call.f_pc", bus.f_pc, 64'h200);
        bus.f_valC = 64'h300;
        tick();
        chk("call2.F_predPC", bus.F_predPC, 64'h300);

        // Mispredict and ret together: mispredict wins.
        bus.F_stall = 1'b1;
        bus.M_icode = 4'h7; bus.M_Cnd = 1'b0; bus.M_valA = 64'h40;
        bus.W_icode = 4'h9; bus.W_valM = 64'h80;
        #1;
        chk("prio.f_pc", bus.f_pc, 64'h40);
        redir_before = m_redir;
        tick();
`ifdef PC_SELECT_PERF_EN
        chk("prio.redirect_inc", 64'(bus.redirect_count), 64'(redir_before + 32'd1));
`endif
        chk("prio.stall_hold", bus.F_predPC, 64'h300);
        bus.M_Cnd = 1'b1;
        #1;
        chk("ret.f_pc", bus.f_pc, 64'h80);
        bus.M_icode = 4'h1; bus.W_icode = 4'h1;

        // Stall for three cycles, then release.
        bus.f_icode = 4'h1; bus.f_valP = 64'h50;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d.F_predPC", i), bus.F_predPC, 64'h300);
        end
        bus.F_stall = 1'b0;
        tick();
        chk("unstall.F_predPC", bus.F_predPC, 64'h50);
        check_all("unstall");

        // Memory error dominates any icode.
        bus.f_imem_error = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.f_icode = 4'(i * 3);
            #1;
            chk($sformatf("imem%0d.f_stat", i), 64'(bus.f_stat), 64'd3);
        end
        bus.f_imem_error = 1'b0;

        // A fetched HALT alone must not stop the processor.
        bus.f_icode = 4'h0;
        tick();
        chk("wrongpath_halt.halted", 64'(bus.halted), 64'd0);

        // W-stage halt freezes F_predPC.
        bus.f_icode = 4'h1; bus.W_stat = 3'd2;
        tick();
        chk("halt.halted", 64'(bus.halted), 64'd1);
        bus.W_stat = 3'd1;
        frozen = m_pred;
        for (int i = 0; i < 5; i++) begin
            bus.f_valP = {$urandom, $urandom};
            tick();
            chk($sformatf("frozen%0d.F_predPC", i), bus.F_predPC, frozen);
            chk($sformatf("frozen%0d.halted", i), 64'(bus.halted), 64'd1);
        end
        bus.M_icode = 4'h7; bus.M_Cnd = 1'b0; bus.M_valA = 64'h77;
        #1;
        chk("halted_redirect.f_pc", bus.f_pc, 64'h77);
        check_all("halted");

        async_reset_pulse("midrun");
        idle_inputs();
        tick();
        check_all("post_reset");

        // Random traffic against the model.
        for (int it = 0; it < 400; it++) begin
            bus.F_stall       = ($urandom_range(0, 3) == 0);
            bus.f_icode       = 4'($urandom_range(0, 11));
            bus.f_valC        = {$urandom, $urandom};
            bus.f_valP        = {$urandom, $urandom};
            bus.f_instr_valid = ($urandom_range(0, 9) != 0);
            bus.f_imem_error  = ($urandom_range(0, 9) == 0);
            bus.M_icode       = ($urandom_range(0, 2) == 0) ? 4'h7 : 4'($urandom_range(0, 11));
            bus.M_Cnd         = 1'($urandom);
            bus.M_valA        = {$urandom, $urandom};
            bus.W_icode       = ($urandom_range(0, 3) == 0) ? 4'h9 : 4'($urandom_range(0, 11));
            bus.W_valM        = {$urandom, $urandom};
            bus.W_stat        = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            #1;
            check_all($sformatf("rnd%0d.pre", it));
            tick();
            check_all($sformatf("rnd%0d.post", it));
            if (it % 50 == 49) async_reset_pulse($sformatf("rnd%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_select_freg.md
Name: pc_select_freg

Overview:
- F-stage pipeline register and PC-selection logic for the pipelined Y86-64 processor.
- Sits directly upstream of fetch: holds the predicted PC and drives the fetch PC each cycle.
- Selects the fetch PC from three sources: the prediction, a mispredicted-branch recovery from M, or a ret target from W.
- Computes the fetched instruction's status code and owns the sticky processor-halted state.

Parameters:
- RESET_PC, 64'h0, PC loaded into F_predPC on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- F_stall  in  1  hold F_predPC (from pipeline control).
- f_icode  in  4  icode decoded by fetch for current f_pc.
- f_valC  in  64  constant word from fetch.
- f_valP  in  64  fall-through PC from fetch.
- f_instr_valid  in  1  fetch found a legal icode/ifun.
- f_imem_error  in  1  fetch address out of range.
- M_icode  in  4  icode in M stage.
- M_Cnd  in  1  branch condition evaluated for M instruction.
- M_valA  in  64  fall-through PC carried with jXX in M.
- W_icode  in  4  icode in W stage.
- W_valM  in  64  return address read by ret, now in W.
- W_stat  in  3  status of W instruction.
- f_pc  out  64  PC presented to fetch this cycle.
- f_predPC  out  64  next-PC prediction (combinational).
- F_predPC  out  64  registered prediction.
- f_stat  out  3  status of fetched instruction.
- halted  out  1  sticky: processor stopped.

Behaviour:
- Shared constants: IHALT=0, IJXX=7, ICALL=8, IRET=9; SAOK=1, SHLT=2, SADR=3, SINS=4.
- Prediction (combinational):
  - f_icode==IJXX or ICALL -> f_predPC = f_valC.
  - Otherwise -> f_predPC = f_valP.
- PC select (combinational), priority order:
  1. M_icode==IJXX && !M_Cnd -> f_pc = M_valA.
  2. Else W_icode==IRET -> f_pc = W_valM.
  3. Else -> f_pc = F_predPC.
- Mispredict outranks ret when both conditions hold in the same cycle.
- f_stat (combinational), priority order:
  1. f_imem_error -> SADR.
  2. Else !f_instr_valid -> SINS.
  3. Else f_icode==IHALT -> SHLT.
  4. Else SAOK.
- Register F_predPC:
  - Async reset (rst_n low) -> RESET_PC.
  - posedge with !F_stall && !halted -> F_predPC <= f_predPC.
  - Otherwise holds.
  - Latency from f_predPC to F_predPC and hence to f_pc: one cycle.
- halted:
  - Async reset -> 0.
  - posedge with W_stat != SAOK -> set to 1.
  - Cleared only by reset.
  - Once set, F_predPC is frozen; f_pc still follows the select logic.
- Only W-stage status can halt the pipeline; a HALT fetched on a wrong path never stops the processor.
- F_stall together with a mispredict: F_predPC holds, but f_pc is still the recovery PC (M_valA). Stall suppresses only the register update.
- Reset asserted mid-operation:
  - All state clears immediately; f_pc = RESET_PC on the first cycle after reset.
  - No partial update on the edge coincident with reset release.
- Widths: all PC arithmetic is 64-bit, wrapping modulo 2^64; no overflow detection.

Optional Feature:
- Macro: PC_SELECT_PERF_EN.
- When defined, adds outputs fetch_count[31:0] and redirect_count[31:0]. Both reset to 0 and saturate at 32'hFFFFFFFF.
  - fetch_count increments on each posedge with !F_stall && !halted.
  - redirect_count increments on each posedge where priority 1 or 2 of PC select applies.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include (y86_defs): icode constants, stat codes, 64-bit word width.
- One natural sub-module, pc_predictor: combinational f_predPC plus f_stat generation.
- pc_select_freg holds the registers, select mux, halt latch and optional counters.

Test Plan:
- Reset with RESET_PC=0x100 -> F_predPC=0x100, f_pc=0x100, halted=0, counters 0.
- f_icode=ICALL, f_valC=0x200, f_valP=0x109, no stall -> next cycle F_predPC=0x200, f_pc=0x200.
- F_predPC=0x300; M_icode=IJXX, M_Cnd=0, M_valA=0x40 and simultaneously W_icode=IRET, W_valM=0x80 -> f_pc=0x40 same cycle; redirect_count +1.
- F_stall=1 for 3 cycles with f_valP=0x50 -> F_predPC unchanged; released -> F_predPC=0x50 next cycle.
- f_imem_error=1 -> f_stat=SADR regardless of f_icode. W_stat=SHLT -> halted=1 next edge, then F_predPC frozen over 5 further cycles.
- rst_n pulsed low mid-run while halted=1 -> halted=0, F_predPC=RESET_PC immediately (asynchronous, no clock edge needed).
